// File: rtl/pipe_wb_regfile_pkg.sv
// Shared constants and types for the writeback stage and CPU register file.
package pipe_wb_regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int NREGS_DEF  = 32;
   localparam int CNT_W_DEF  = 32;
   localparam int RN_W       = 5;

   typedef logic [RN_W-1:0] reg_num_t;

   localparam reg_num_t REG_ZERO = 5'd0;

   function automatic logic is_zero_reg(input reg_num_t rn);
      return rn == REG_ZERO;
   endfunction

endpackage

// File: rtl/pipe_wb_regfile_if.sv
// WB-stage inputs, ID/debug read ports and status outputs of the register file.
interface pipe_wb_regfile_if
   import pipe_wb_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   logic              wwreg;
   logic              wm2reg;
   logic [DATA_W-1:0] wmo;
   logic [DATA_W-1:0] walu;
   reg_num_t          wrn;
   reg_num_t          rna;
   reg_num_t          rnb;
   reg_num_t          dbg_rn;
   logic [DATA_W-1:0] qa;
   logic [DATA_W-1:0] qb;
   logic [DATA_W-1:0] dbg_q;
   logic [DATA_W-1:0] wdi;
   logic              wb_commit;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      output wwreg, wm2reg, wmo, walu, wrn, rna, rnb, dbg_rn,
      input  qa, qb, dbg_q, wdi, wb_commit, retire_cnt
   );

   modport slave (
      input  wwreg, wm2reg, wmo, walu, wrn, rna, rnb, dbg_rn,
      output qa, qb, dbg_q, wdi, wb_commit, retire_cnt
   );
endinterface

// File: rtl/pipe_wb_regfile_readport.sv
// One register-file read port: r0 reads zero, optional same-cycle write bypass, else array.
module pipe_rf_readport
   import pipe_wb_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF
)(
   input  reg_num_t          rn,
   input  logic              bypass_en,
   input  reg_num_t          wn,
   input  logic [DATA_W-1:0] wd,
   input  logic [DATA_W-1:0] regs [NREGS],
   output logic [DATA_W-1:0] q
);
   always_comb begin
      q = regs[rn];
      if (is_zero_reg(rn)) begin
         q = '0;
      end else if (bypass_en && (rn == wn)) begin
         q = wd;
      end
   end
endmodule

// File: rtl/pipe_wb_regfile.sv
// Writeback value select, 32x32 register file with bypassed ID reads, debug read, retire counter.
module pipe_wb_regfile
   import pipe_wb_regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int CNT_W  = CNT_W_DEF
)(
   input  logic              clock,
   input  logic              resetn,
   pipe_wb_regfile_if.slave  bus
);
   logic [DATA_W-1:0] regs_reg [NREGS];
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] wdi;
   logic              commit;

   assign wdi    = bus.wm2reg ? bus.wmo : bus.walu;
   // Gating with resetn also disables the read bypass during reset.
   assign commit = resetn & bus.wwreg & ~is_zero_reg(bus.wrn);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
         cnt_reg <= '0;
      end else if (commit) begin
         regs_reg[bus.wrn] <= wdi;
         cnt_reg           <= cnt_reg + CNT_W'(1);
      end
   end

   pipe_rf_readport #(.DATA_W(DATA_W), .NREGS(NREGS)) u_port_a (
      .rn        (bus.rna),
      .bypass_en (commit),
      .wn        (bus.wrn),
      .wd        (wdi),
      .regs      (regs_reg),
      .q         (bus.qa)
   );

   pipe_rf_readport #(.DATA_W(DATA_W), .NREGS(NREGS)) u_port_b (
      .rn        (bus.rnb),
      .bypass_en (commit),
      .wn        (bus.wrn),
      .wd        (wdi),
      .regs      (regs_reg),
      .q         (bus.qb)
   );

   // Debug port shows committed state only.
   pipe_rf_readport #(.DATA_W(DATA_W), .NREGS(NREGS)) u_port_dbg (
      .rn        (bus.dbg_rn),
      .bypass_en (1'b0),
      .wn        (REG_ZERO),
      .wd        ('0),
      .regs      (regs_reg),
      .q         (bus.dbg_q)
   );

   assign bus.wdi        = wdi;
   assign bus.wb_commit  = commit;
   assign bus.retire_cnt = cnt_reg;
endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Randomised and directed bench for pipe_wb_regfile against an array/counter reference model.
module tb_pipe_wb_regfile;
   import pipe_wb_regfile_pkg::*;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   pipe_wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();
   pipe_wb_regfile_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

   pipe_wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(32)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   // Narrow-counter copy sees the same traffic; only its counter is checked.
   pipe_wb_regfile #(.DATA_W(32), .NREGS(32), .CNT_W(4)) dut4 (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus4)
   );

   assign bus4.wwreg  = bus.wwreg;
   assign bus4.wm2reg = bus.wm2reg;
   assign bus4.wmo    = bus.wmo;
   assign bus4.walu   = bus.walu;
   assign bus4.wrn    = bus.wrn;
   assign bus4.rna    = bus.rna;
   assign bus4.rnb    = bus.rnb;
   assign bus4.dbg_rn = bus.dbg_rn;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;
   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] exp_wdi();
      return bus.wm2reg ? bus.wmo : bus.walu;
   endfunction

   function automatic logic exp_commit();
      return resetn && bus.wwreg && (bus.wrn != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] rn, input logic use_bypass);
      if (rn == 5'd0) return 32'd0;
      if (use_bypass && exp_commit() && rn == bus.wrn) return exp_wdi();
      return m_regs[rn];
   endfunction

   task automatic model_edge();
      if (!resetn) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_cnt = 32'd0;
      end else if (bus.wwreg && bus.wrn != 5'd0) begin
         m_regs[bus.wrn] = exp_wdi();
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic drive(input logic rst_n, input logic we, input logic m2r,
                        input logic [31:0] mo, input logic [31:0] alu,
                        input logic [4:0] wn, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d);
      @(negedge clock);
      resetn     = rst_n;
      bus.wwreg  = we;
      bus.wm2reg = m2r;
      bus.wmo    = mo;
      bus.walu   = alu;
      bus.wrn    = wn;
      bus.rna    = a;
      bus.rnb    = b;
      bus.dbg_rn = d;
   endtask

   task automatic clock_edge();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      clock_edge();
      drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      clock_edge();
      for (int i = 0; i < 32; i++) begin
         bus.dbg_rn = 5'(i);
         #1;
         n_checks++;
         if (bus.dbg_q !== 32'd0) $display("FAIL reset_dbg r%0d: got %h want 0", i, bus.dbg_q);
         else n_pass++;
      end
      n_checks++;
      if (bus.retire_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", bus.retire_cnt);
      else n_pass++;
      $display("reset: dbg sweep and counter checked");
   endtask

   task automatic test_alu_write();
      drive(1, 1, 0, 32'h0, 32'h1234_5678, 5'd5, 5'd5, 5'd3, 5'd5);
      #1;
      n_checks++;
      if (bus.qa !== 32'h1234_5678) $display("FAIL alu_bypass_qa: got %h want 12345678", bus.qa);
      else n_pass++;
      n_checks++;
      if (bus.wb_commit !== 1'b1) $display("FAIL alu_commit: got %b want 1", bus.wb_commit);
      else n_pass++;
      n_checks++;
      if (bus.dbg_q !== 32'd0) $display("FAIL alu_dbg_nobypass: got %h want 0", bus.dbg_q);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (bus.dbg_q !== 32'h1234_5678) $display("FAIL alu_dbg_after: got %h want 12345678", bus.dbg_q);
      else n_pass++;
      n_checks++;
      if (bus.retire_cnt !== 32'd1) $display("FAIL alu_cnt: got %0d want 1", bus.retire_cnt);
      else n_pass++;
      $display("alu write: r5 <= 12345678, retire_cnt=%0d", bus.retire_cnt);
   endtask

   task automatic test_load_write();
      drive(1, 1, 1, 32'hDEAD_BEEF, 32'h0, 5'd31, 5'd31, 5'd31, 5'd31);
      #1;
      n_checks++;
      if (bus.wdi !== 32'hDEAD_BEEF) $display("FAIL load_wdi: got %h want deadbeef", bus.wdi);
      else n_pass++;
      n_checks++;
      if (bus.qa !== 32'hDEAD_BEEF || bus.qb !== 32'hDEAD_BEEF)
         $display("FAIL load_dual_bypass: got qa=%h qb=%h want deadbeef", bus.qa, bus.qb);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (bus.dbg_q !== 32'hDEAD_BEEF) $display("FAIL load_r31: got %h want deadbeef", bus.dbg_q);
      else n_pass++;
      $display("load write: r31 <= deadbeef");
   endtask

   task automatic test_r0_protect();
      drive(1, 1, 0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd5, 5'd0);
      #1;
      n_checks++;
      if (bus.wb_commit !== 1'b0) $display("FAIL r0_commit: got %b want 0", bus.wb_commit);
      else n_pass++;
      n_checks++;
      if (bus.qa !== 32'd0) $display("FAIL r0_qa: got %h want 0", bus.qa);
      else n_pass++;
      n_checks++;
      if (bus.qb !== 32'h1234_5678) $display("FAIL r0_qb_r5: got %h want 12345678", bus.qb);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (bus.retire_cnt !== 32'd2) $display("FAIL r0_cnt: got %0d want 2", bus.retire_cnt);
      else n_pass++;
      n_checks++;
      if (bus.dbg_q !== 32'd0) $display("FAIL r0_dbg: got %h want 0", bus.dbg_q);
      else n_pass++;
      $display("r0 write dropped, retire_cnt=%0d", bus.retire_cnt);
   endtask

   task automatic test_reset_mid_write();
      drive(1, 1, 0, 32'h0, 32'h1111_1111, 5'd7, 5'd7, 5'd7, 5'd7);
      clock_edge();
      drive(0, 1, 0, 32'h0, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7, 5'd7);
      #1;
      n_checks++;
      if (bus.wb_commit !== 1'b0) $display("FAIL midrst_commit: got %b want 0", bus.wb_commit);
      else n_pass++;
      n_checks++;
      if (bus.qa !== 32'h1111_1111) $display("FAIL midrst_nobypass: got %h want 11111111", bus.qa);
      else n_pass++;
      clock_edge();
      n_checks++;
      if (bus.dbg_q !== 32'd0 || bus.qa !== 32'd0)
         $display("FAIL midrst_r7: got dbg=%h qa=%h want 0", bus.dbg_q, bus.qa);
      else n_pass++;
      n_checks++;
      if (bus.retire_cnt !== 32'd0) $display("FAIL midrst_cnt: got %0d want 0", bus.retire_cnt);
      else n_pass++;
      $display("reset mid-write: r7 cleared, retire_cnt=%0d", bus.retire_cnt);
   endtask

   task automatic test_random();
      logic [4:0] wn, a, b, d;
      for (int t = 0; t < 200; t++) begin
         wn = 5'($urandom_range(0, 31));
         a  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
         b  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
         d  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
               $urandom, $urandom, wn, a, b, d);
         #1;
         n_checks++;
         if (bus.wdi !== exp_wdi() || bus.wb_commit !== exp_commit())
            $display("FAIL rand_wb t%0d: got wdi=%h commit=%b want wdi=%h commit=%b",
                     t, bus.wdi, bus.wb_commit, exp_wdi(), exp_commit());
         else n_pass++;
         n_checks++;
         if (bus.qa !== exp_read(a, 1'b1) || bus.qb !== exp_read(b, 1'b1))
            $display("FAIL rand_read t%0d: got qa=%h qb=%h want qa=%h qb=%h",
                     t, bus.qa, bus.qb, exp_read(a, 1'b1), exp_read(b, 1'b1));
         else n_pass++;
         n_checks++;
         if (bus.dbg_q !== exp_read(d, 1'b0))
            $display("FAIL rand_dbg t%0d: got %h want %h", t, bus.dbg_q, exp_read(d, 1'b0));
         else n_pass++;
         n_checks++;
         if (bus.retire_cnt !== m_cnt || bus4.retire_cnt !== m_cnt[3:0])
            $display("FAIL rand_cnt t%0d: got %0d/%0d want %0d/%0d",
                     t, bus.retire_cnt, bus4.retire_cnt, m_cnt, m_cnt[3:0]);
         else n_pass++;
         $display("rand t%0d: rst_n=%b we=%b wrn=%0d wdi=%h qa=%h qb=%h cnt=%0d",
                  t, resetn, bus.wwreg, wn, bus.wdi, bus.qa, bus.qb, bus.retire_cnt);
         clock_edge();
      end
   endtask

   task automatic test_counter_wrap();
      logic [3:0] want;
      drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      clock_edge();
      for (int k = 1; k <= 17; k++) begin
         drive(1, 1, 0, 32'd0, $urandom, 5'($urandom_range(1, 31)), 5'd1, 5'd2, 5'd3);
         clock_edge();
         want = 4'(k % 16);
         n_checks++;
         if (bus4.retire_cnt !== want)
            $display("FAIL wrap_cnt k%0d: got %0d want %0d", k, bus4.retire_cnt, want);
         else n_pass++;
         $display("wrap write %0d: retire_cnt(4b)=%0d", k, bus4.retire_cnt);
      end
   endtask

   initial begin
      bus.wwreg = 0; bus.wm2reg = 0; bus.wmo = '0; bus.walu = '0;
      bus.wrn = '0; bus.rna = '0; bus.rnb = '0; bus.dbg_rn = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      test_reset();
      test_alu_write();
      test_load_write();
      test_r0_protect();
      test_reset_mid_write();
      test_random();
      test_counter_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
